// File: rtl/lcd_bus_pkg.sv
// ============================================================================
// lcd_bus_pkg : shared types and constants for the LCD bus responder
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lcd_bus_pkg;

   localparam int         DDRAM_DEPTH = 32;
   localparam int         BUS_W       = 11;
   localparam logic [7:0] SPACE_CHAR  = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   typedef enum logic [3:0] {
      CMD_NOP   = 4'd0,
      CMD_CLEAR = 4'd1,
      CMD_HOME  = 4'd2,
      CMD_ENTRY = 4'd3,
      CMD_DISP  = 4'd4,
      CMD_SHIFT = 4'd5,
      CMD_FUNC  = 4'd6,
      CMD_CGRAM = 4'd7,
      CMD_DDRAM = 4'd8
   } cmd_t;

   // The highest set bit of an instruction byte selects its class.
   function automatic cmd_t decode_cmd(input logic [7:0] d);
      cmd_t c;
      if (d[7])      c = CMD_DDRAM;
      else if (d[6]) c = CMD_CGRAM;
      else if (d[5]) c = CMD_FUNC;
      else if (d[4]) c = CMD_SHIFT;
      else if (d[3]) c = CMD_DISP;
      else if (d[2]) c = CMD_ENTRY;
      else if (d[1]) c = CMD_HOME;
      else if (d[0]) c = CMD_CLEAR;
      else           c = CMD_NOP;
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_responder_sync.sv
// ============================================================================
// lcd_sync_edge : 2-flop synchronizer for the LCD bus, falling-edge strobe on E
// Revision      : 1.0
// ============================================================================
`default_nettype none

module lcd_sync_edge
   import lcd_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   output logic       strobe,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data
);

   logic [BUS_W-1:0] s1_q, s1_d;
   logic [BUS_W-1:0] s2_q, s2_d;
   logic             e_prev_q, e_prev_d;

   always_comb begin
      s1_d     = {lcd_e, lcd_rs, lcd_rw, lcd_data};
      s2_d     = s1_q;
      e_prev_d = s2_q[10];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         e_prev_q <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         e_prev_q <= e_prev_d;
      end
   end

   // rs/rw/data come from the same stage as the E level that completes the edge.
   assign strobe = e_prev_q & ~s2_q[10];
   assign rs     = s2_q[9];
   assign rw     = s2_q[8];
   assign data   = s2_q[7:0];

endmodule

`default_nettype wire

// File: rtl/lcd_bus_responder.sv
// ============================================================================
// lcd_bus_responder : decodes LCD write transactions into a 2-row shadow DDRAM
// Revision          : 1.0
// ============================================================================
`default_nettype none

module lcd_bus_responder
   import lcd_bus_pkg::*;
#(
   parameter int HOLD_CYCLES = 16,
   parameter int ROW_LEN     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [4:0] cursor,
   output logic       disp_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       two_line,
   output logic       busy,
   output logic       cmd_valid,
   output logic       err
);

   localparam int         HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [3:0] LAST_COL  = 4'(ROW_LEN - 1);
   localparam logic [4:0] ROW_LEN_W = 5'(ROW_LEN);

   logic       sync_strobe, sync_rs, sync_rw;
   logic [7:0] sync_data;
   cmd_t       cmd_class;

   state_t           state_q, state_d;
   logic [4:0]       clr_cnt_q, clr_cnt_d;
   logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [4:0]       cursor_q, cursor_d;
   logic             inc_q, inc_d;
   logic             disp_on_q, disp_on_d;
   logic             cursor_on_q, cursor_on_d;
   logic             blink_on_q, blink_on_d;
   logic             two_line_q, two_line_d;
   logic             busy_q, busy_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             err_q, err_d;
   logic [7:0]       rd_char_q, rd_char_d;

   logic [7:0]       mem_q [DDRAM_DEPTH];
   logic             mem_we;
   logic [4:0]       mem_waddr;
   logic [7:0]       mem_wdata;

   lcd_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .lcd_e    (lcd_e),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_data (lcd_data),
      .strobe   (sync_strobe),
      .rs       (sync_rs),
      .rw       (sync_rw),
      .data     (sync_data)
   );

   assign cmd_class = decode_cmd(sync_data);

   // Column wraps onto the other row; the row bit toggling gives 31->0 and 0->31.
   function automatic logic [4:0] step_cursor(input logic [4:0] c, input logic up);
      logic [4:0] n;
      if (up) n = (c[3:0] == LAST_COL) ? {~c[4], 4'd0} : {c[4], c[3:0] + 4'd1};
      else    n = (c[3:0] == 4'd0)     ? {~c[4], LAST_COL} : {c[4], c[3:0] - 4'd1};
      return n;
   endfunction

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      cursor_d    = cursor_q;
      inc_d       = inc_q;
      disp_on_d   = disp_on_q;
      cursor_on_d = cursor_on_q;
      blink_on_d  = blink_on_q;
      two_line_d  = two_line_q;
      err_d       = err_q;
      cmd_valid_d = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = cursor_q;
      mem_wdata   = sync_data;
      rd_char_d   = mem_q[rd_addr];

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = SPACE_CHAR;
            if (clr_cnt_q == 5'(DDRAM_DEPTH - 1)) state_d = ST_IDLE;
            else                                  clr_cnt_d = clr_cnt_q + 5'd1;
         end
         ST_HOLD: begin
            if (hold_cnt_q == HCW'(HOLD_CYCLES - 1)) state_d = ST_IDLE;
            else                                     hold_cnt_d = hold_cnt_q + 1'b1;
         end
         default: ;
      endcase

      if (sync_strobe && !sync_rw) begin
         if (state_q != ST_IDLE) begin
            err_d = 1'b1;
         end else begin
            cmd_valid_d = 1'b1;
            if (sync_rs) begin
               mem_we   = 1'b1;
               cursor_d = step_cursor(cursor_q, inc_q);
            end else begin
               case (cmd_class)
                  CMD_CLEAR: begin
                     cursor_d  = 5'd0;
                     inc_d     = 1'b1;
                     clr_cnt_d = 5'd0;
                     state_d   = ST_CLEAR;
                  end
                  CMD_HOME: begin
                     cursor_d   = 5'd0;
                     hold_cnt_d = '0;
                     state_d    = ST_HOLD;
                  end
                  CMD_ENTRY: inc_d = sync_data[1];
                  CMD_DISP: begin
                     disp_on_d   = sync_data[2];
                     cursor_on_d = sync_data[1];
                     blink_on_d  = sync_data[0];
                  end
                  CMD_FUNC: two_line_d = sync_data[3];
                  CMD_DDRAM: begin
                     if (sync_data[5:4] == 2'b00 && {1'b0, sync_data[3:0]} < ROW_LEN_W)
                        cursor_d = {sync_data[6], sync_data[3:0]};
                     else
                        err_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clr_cnt_q   <= 5'd0;
         hold_cnt_q  <= '0;
         cursor_q    <= 5'd0;
         inc_q       <= 1'b1;
         disp_on_q   <= 1'b0;
         cursor_on_q <= 1'b0;
         blink_on_q  <= 1'b0;
         two_line_q  <= 1'b0;
         busy_q      <= 1'b1;
         cmd_valid_q <= 1'b0;
         err_q       <= 1'b0;
         rd_char_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         cursor_q    <= cursor_d;
         inc_q       <= inc_d;
         disp_on_q   <= disp_on_d;
         cursor_on_q <= cursor_on_d;
         blink_on_q  <= blink_on_d;
         two_line_q  <= two_line_d;
         busy_q      <= busy_d;
         cmd_valid_q <= cmd_valid_d;
         err_q       <= err_d;
         rd_char_q   <= rd_char_d;
      end
   end

   // Contents survive reset; the CLEAR pass that follows reset rewrites them.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign rd_char   = rd_char_q;
   assign cursor    = cursor_q;
   assign disp_on   = disp_on_q;
   assign cursor_on = cursor_on_q;
   assign blink_on  = blink_on_q;
   assign two_line  = two_line_q;
   assign busy      = busy_q;
   assign cmd_valid = cmd_valid_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
Receiving end of the character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data) that the calculator drives.
- Decodes HD44780-style write transactions into a 2x16 shadow DDRAM plus cursor and display-control state.
- Gives benches and a mirror display a synthesizable view of what the panel would show.
- Sits beside the calculator top and observes the LCD bus only; it never drives the bus.

Parameters:
HOLD_CYCLES, 16, busy duration in clk cycles after a Return Home command
ROW_LEN, 16, characters per row; the block has two rows, 2*ROW_LEN DDRAM entries

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
lcd_e  input  1  LCD enable strobe; a transaction is captured on its falling edge
lcd_rs  input  1  0 = command, 1 = data
lcd_rw  input  1  0 = write, 1 = read (reads are ignored)
lcd_data  input  8  LCD data bus
rd_addr  input  5  shadow-DDRAM read index ({row, col[3:0]})
rd_char  output  8  character at rd_addr, registered
cursor  output  5  current address counter ({row, col})
disp_on  output  1  display-on bit (D)
cursor_on  output  1  cursor bit (C)
blink_on  output  1  blink bit (B)
two_line  output  1  N bit from Function Set
busy  output  1  high while the block is clearing or holding
cmd_valid  output  1  one-cycle pulse per accepted write transaction
err  output  1  sticky error flag, cleared only by rst

Behaviour:
- Bus input sampling: all four bus inputs pass through a 2-flop synchronizer.
  - Falling edge of synchronized lcd_e = transaction; rs/rw/data are taken from the same synchronized stage.
  - Effects (memory, cursor, flags, cmd_valid) are visible 3 clk edges after the first edge that samples lcd_e low.
- Reads: lcd_rw=1 transactions are ignored entirely (no cmd_valid, no err).
- Reset values (asynchronous):
  - cursor=0, disp_on=0, cursor_on=0, blink_on=0, two_line=0, cmd_valid=0, err=0, rd_char=0x00.
  - Entry-mode increment=1.
  - FSM enters CLEAR, so busy=1 immediately.
- FSM states: IDLE, CLEAR, HOLD.
  - IDLE: accepts transactions.
  - CLEAR: writes 0x20 to entry k on the k-th cycle, k=0..31; goes to IDLE after entry 31 is written (32 cycles busy).
  - HOLD: counts HOLD_CYCLES cycles, then goes to IDLE.
  - busy = (state != IDLE), registered.
- Write while busy: dropped, err<=1, no cmd_valid. This includes a transaction detected on the last busy cycle.
- Rst mid-CLEAR or mid-HOLD restarts CLEAR from entry 0.
- Command decode (rs=0); the highest set bit selects the command:
  - 0x01 Clear: cursor=0, increment=1, go to CLEAR.
  - 0x02/0x03 Return Home: cursor=0, memory unchanged, go to HOLD.
  - 0x04-0x07 Entry Mode: increment = d[1]; shift bit d[0] ignored.
  - 0x08-0x0F Display Control: disp_on=d[2], cursor_on=d[1], blink_on=d[0].
  - 0x10-0x1F Cursor/Display Shift: ignored.
  - 0x20-0x3F Function Set: two_line = d[3].
  - 0x40-0x7F CGRAM address: ignored.
  - 0x80-0xFF Set DDRAM Address: a = d[6:0].
    - If a[5:4]==0 and a[3:0]<ROW_LEN: cursor = {a[6], a[3:0]}.
    - Otherwise cursor is unchanged and err<=1.
  - cmd_valid pulses for every accepted write, including ignored commands.
- Data write (rs=1): mem[cursor] <= lcd_data; then cursor moves.
  - Increment: col 15 -> col 0 of the other row; 31 wraps to 0.
  - Decrement: 0 wraps to 31; col 0 of row 1 -> col 15 of row 0.
- Read port: rd_char <= mem[rd_addr] every cycle, 1-cycle latency.
  - A write and a read of the same entry in the same cycle return the old value.
  - During CLEAR, already-filled entries read 0x20; unfilled entries return their prior contents.

Decomposition:
- Shared package lcd_bus_pkg:
  - command class constants (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM)
  - FSM state encoding
  - SPACE_CHAR = 8'h20
  - DDRAM_DEPTH = 32
- Sub-module lcd_sync_edge: 2-flop synchronizer for the 11 bus bits, plus falling-edge detect on lcd_e. Outputs a one-cycle strobe with the aligned rs/rw/data.

Test Plan:
- Release rst: busy=1 for 32 cycles, then 0 -> all 32 rd_char reads = 0x20, cursor=0, err=0.
- Write cmd 0x0E, then data 0x31,0x32 -> disp_on=1, cursor_on=1, blink_on=0; mem[0]=0x31, mem[1]=0x32, cursor=2; three cmd_valid pulses.
- Cmd 0xCF, then data 0x41,0x42 -> mem[31]=0x41, mem[0]=0x42 (wrap), cursor=1.
- Cmd 0x04, cmd 0x80, data 0x58 -> mem[0]=0x58, cursor=31 (decrement wrap).
- Cmd 0x01, then data write 5 cycles later -> write dropped, err=1, busy stays 32 cycles; afterwards all entries read 0x20 and cursor=0.
- Cmd 0x90 -> err=1, cursor unchanged.
- Data write with lcd_rw=1 -> memory, cursor and err unchanged; no cmd_valid.
- Assert rst mid-HOLD (after cmd 0x02) -> outputs take reset values at once, and CLEAR restarts from entry 0.
